seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 4'b1010, meaning target sequence, width PAT_W; PATTERN[PAT_W-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 0, meaning 0 = non-overlapping detection, 1 = overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port in  input  1  serial data bit.
REQ-008 SHALL have port in_en  input  1  qualifier; in is consumed only on edges where in_en=1.
REQ-009 SHALL have port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-010 SHALL have port out  output  1  registered match pulse.
REQ-011 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-012 SHALL have port ps  output  $clog2(PAT_W)  current state, for debug visibility.

Function
REQ-013 SHALL implement states S0..S(PAT_W-1), where Sk means the last k consumed bits equal the first k pattern bits and k is the longest such prefix.
REQ-014 On a consumed bit that does not complete the pattern, next state SHALL be the longest pattern prefix that is a suffix of (current prefix + in); it falls back correctly, e.g. 1010 with prefix "101" and in=1 goes to S1.
REQ-015 On a consumed bit that completes the pattern, out SHALL be 1 for exactly the next cycle.
REQ-016 On a completing bit with OVERLAP=0, next state SHALL be S0.
REQ-017 On a completing bit with OVERLAP=1, next state SHALL be S(B), B = length of the longest proper border of PATTERN (B=2 for 1010, B=0 for 1000).
REQ-018 Match latency SHALL be one cycle: out rises on the edge that samples the final pattern bit.
REQ-019 With in_en=0, state and match_cnt SHALL hold and out SHALL be 0 the following cycle.
REQ-020 On each match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-021 When clr_cnt=1, match_cnt SHALL become 0 on the next edge; clr_cnt SHALL have priority over a simultaneous match, while out still pulses and the state still advances.
REQ-022 All failure and border transitions SHALL be derived from PATTERN at elaboration time; no per-pattern hand-coded tables.

Reset
REQ-023 When rst=1 at an edge, the next values SHALL be ps=S0, out=0 and match_cnt=0, regardless of in_en or clr_cnt.
REQ-024 Reset mid-match SHALL discard partial progress; a pattern straddling reset deassertion SHALL NOT be detected.
REQ-025 No output SHALL change asynchronously to clk.

Structure
REQ-026 The state encoding width and the border-length elaboration function SHALL live in shared package seq_det_pkg.
REQ-027 The saturating match counter SHALL be sub-module sat_cnt, parameterised by CNT_W, with ports clk, rst, clr, inc and q.
REQ-028 The next-state logic SHALL be purely combinational from ps, in and parameters; ps, out and the counter are the only registers.

Verification
REQ-029 Defaults, rst released, stream 1,0,1,0,1,0,1,0 with in_en=1 -> out pulses after bits 4 and 8; match_cnt=2.
REQ-030 Same stream with OVERLAP=1 -> out pulses after bits 4, 6 and 8; match_cnt=3.
REQ-031 Stream 1,0,1,1,0,1,0 (defaults) -> no pulse at bit 4 (falls to S1); single pulse after bit 7.
REQ-032 Stream 1,0,1 then in_en=0 for 3 cycles with in toggling, then 0 -> state held at S3; single pulse after the final 0.
REQ-033 CNT_W=2 with 5 matches -> match_cnt saturates at 3; clr_cnt asserted together with a 6th match -> match_cnt=0 and out=1.
REQ-034 rst asserted after 1,0,1, then 0 after release -> no pulse and ps=S0; PAT_W=6, PATTERN=6'b110110, OVERLAP=1 on stream 110110110 -> pulses after bits 6 and 9.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// Pattern bit i (0 = first received) lives at PATTERN[w-1-i].
package seq_det_pkg;

  function automatic int st_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic pat_bit(
    input logic [31:0] p,
    input int          w,
    input int          i
  );
    return p[w-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix k) followed by b,
  // capped below w since a full match is handled outside the table.
  function automatic int next_pfx(
    input logic [31:0] p,
    input int          w,
    input int          k,
    input logic        b
  );
    int   best;
    int   pos;
    logic ok;
    logic s;
    best = 0;
    for (int j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        pos = k + 1 - j + i;
        s = (pos == k) ? b : pat_bit(p, w, pos);
        if (s != pat_bit(p, w, i)) ok = 1'b0;
      end
      if (ok && j < w) best = j;
    end
    return best;
  endfunction

  function automatic int border_len(
    input logic [31:0] p,
    input int          w
  );
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < w; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pat_bit(p, w, i) != pat_bit(p, w, w - j + i)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_param_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_det_param.sv
// Parameterised serial sequence detector with KMP-style fallback table
// built at elaboration, optional overlap, and a saturating match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               OVERLAP = 0,
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in,
  input  logic                     in_en,
  input  logic                     clr_cnt,
  output logic                     out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(PAT_W)-1:0] ps
);

  localparam int SW     = st_w(PAT_W);
  localparam int TW     = 2 * PAT_W * SW;
  localparam int BORDER = border_len(32'(PATTERN), PAT_W);

  function automatic logic [TW-1:0] build_tbl();
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < PAT_W; k++) begin
      for (int b = 0; b < 2; b++) begin
        t[(2*k+b)*SW +: SW] =
          SW'(next_pfx(32'(PATTERN), PAT_W, k, b[0]));
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] NXT_TBL = build_tbl();
  localparam logic [SW-1:0] LAST    = SW'(PAT_W - 1);
  localparam logic [SW-1:0] RESTART =
    (OVERLAP != 0) ? SW'(BORDER) : '0;

  logic [SW-1:0] ps_q;
  logic [SW-1:0] ps_d;
  logic          out_q;
  logic          out_d;
  logic          hit;
  int            idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q  <= '0;
      out_q <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    ps_d = ps_q;
    idx  = (2 * int'(ps_q) + int'(in)) * SW;
    if (in_en) begin
      if (hit) ps_d = RESTART;
      else     ps_d = NXT_TBL[idx +: SW];
    end
  end

  always_comb begin
    hit   = in_en && (ps_q == LAST) && (in == PATTERN[0]);
    out_d = hit;
  end

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (hit),
    .q   (match_cnt)
  );

  assign out = out_q;
  assign ps  = ps_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench: four detector configurations share one stimulus stream.
module tb_seq_det_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_b = 1'b0;
  logic in_en = 1'b0;
  logic clr_cnt = 1'b0;

  logic       a_out, b_out, c_out, d_out;
  logic [7:0] a_cnt, b_cnt, d_cnt;
  logic [1:0] c_cnt;
  logic [1:0] a_ps, b_ps, c_ps;
  logic [2:0] d_ps;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_param u_a (
    .clk(clk), .rst(rst), .in(in_b), .in_en(in_en),
    .clr_cnt(clr_cnt), .out(a_out), .match_cnt(a_cnt), .ps(a_ps)
  );

  seq_det_param #(.OVERLAP(1)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .in_en(in_en),
    .clr_cnt(clr_cnt), .out(b_out), .match_cnt(b_cnt), .ps(b_ps)
  );

  seq_det_param #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in(in_b), .in_en(in_en),
    .clr_cnt(clr_cnt), .out(c_out), .match_cnt(c_cnt), .ps(c_ps)
  );

  seq_det_param #(
    .PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1)
  ) u_d (
    .clk(clk), .rst(rst), .in(in_b), .in_en(in_en),
    .clr_cnt(clr_cnt), .out(d_out), .match_cnt(d_cnt), .ps(d_ps)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic en);
    @(negedge clk);
    in_b = b;
    in_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_en = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] va, vb, vd;
  logic [7:0]  s8;
  logic [8:0]  s9;

  initial begin
    do_reset();
    chk("rst_out", {31'd0, a_out}, 32'd0);
    chk("rst_ps", {30'd0, a_ps}, 32'd0);
    chk("rst_cnt", {24'd0, a_cnt}, 32'd0);

    // 10101010: non-overlap vs overlap
    s8 = 8'b10101010;
    va = '0; vb = '0;
    for (int i = 0; i < 8; i++) begin
      step(s8[7-i], 1'b1);
      va[i] = a_out;
      vb[i] = b_out;
      if (i == 3) chk("ovl_ps_b4", {30'd0, b_ps}, 32'd2);
    end
    chk("nonovl_pulses", {16'd0, va}, 32'h88);
    chk("ovl_pulses", {16'd0, vb}, 32'hA8);
    chk("nonovl_cnt", {24'd0, a_cnt}, 32'd2);
    chk("ovl_cnt", {24'd0, b_cnt}, 32'd3);

    // 1011010: fallback from S3 on a 1
    do_reset();
    s8 = 8'b10110100;
    va = '0;
    for (int i = 0; i < 7; i++) begin
      step(s8[7-i], 1'b1);
      va[i] = a_out;
      if (i == 3) chk("fallback_ps", {30'd0, a_ps}, 32'd1);
    end
    chk("fallback_pulses", {16'd0, va}, 32'h40);
    chk("fallback_cnt", {24'd0, a_cnt}, 32'd1);

    // 101, three idle cycles with toggling data, then 0
    do_reset();
    va = '0;
    step(1'b1, 1'b1); va[0] = a_out;
    step(1'b0, 1'b1); va[1] = a_out;
    step(1'b1, 1'b1); va[2] = a_out;
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b1 : 1'b0, 1'b0);
      va[3+i] = a_out;
      chk("hold_ps", {30'd0, a_ps}, 32'd3);
    end
    step(1'b0, 1'b1); va[6] = a_out;
    chk("hold_pulses", {16'd0, va}, 32'h40);
    chk("hold_cnt", {24'd0, a_cnt}, 32'd1);

    // saturation at 3 with CNT_W=2, then clear racing a match
    do_reset();
    for (int m = 0; m < 5; m++) begin
      step(1'b1, 1'b1); step(1'b0, 1'b1);
      step(1'b1, 1'b1); step(1'b0, 1'b1);
      if (m == 2) chk("sat_cnt_3", {30'd0, c_cnt}, 32'd3);
    end
    chk("sat_cnt_5", {30'd0, c_cnt}, 32'd3);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    @(negedge clk);
    in_b = 1'b0; in_en = 1'b1; clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_cnt", {30'd0, c_cnt}, 32'd0);
    chk("clr_out", {31'd0, c_out}, 32'd1);
    @(negedge clk);
    clr_cnt = 1'b0;

    // reset mid-pattern with clr/en asserted, then the final 0
    do_reset();
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_b = 1'b0; in_en = 1'b1; clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ps", {30'd0, a_ps}, 32'd0);
    chk("midrst_out", {31'd0, a_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0; clr_cnt = 1'b0;
    step(1'b0, 1'b1);
    chk("postrst_out", {31'd0, a_out}, 32'd0);
    chk("postrst_ps", {30'd0, a_ps}, 32'd0);

    // 6-bit pattern 110110 with overlap
    do_reset();
    s9 = 9'b110110110;
    vd = '0;
    for (int i = 0; i < 9; i++) begin
      step(s9[8-i], 1'b1);
      vd[i] = d_out;
      if (i == 5) chk("p6_ps_border", {29'd0, d_ps}, 32'd3);
    end
    chk("p6_pulses", {16'd0, vd}, 32'h120);
    chk("p6_cnt", {24'd0, d_cnt}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
